// File: rtl/risc5_gpio_timer.sv
// RISC5 GPIO and millisecond-timer peripheral: synchronised pins, edge interrupts, loadable ms counter.
// Optional compare/interrupt logic (regs 6, 7) is built when GPIO_TMR_COMPARE_EN is defined.
module risc5_gpio_timer #(
    parameter int GPIO_W   = 8,
    parameter int TICK_DIV = 25000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rd,
    input  logic              wr,
    input  logic [2:0]        wadr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              tick,
    output logic              irq
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [GPIO_W-1:0] s1, s2, s3;
    logic [GPIO_W-1:0] est, ren, fen;
    logic [GPIO_W-1:0] wd, edges;
    logic [PW-1:0]     pre;
    logic [31:0]       ms;
    logic              we, tick_hit, ms_wr;
    logic              rd_unused;

    assign rd_unused = rd;
    assign we        = sel & wr;
    assign wd        = wdata[GPIO_W-1:0];
    assign edges     = (s2 & ~s3 & ren) | (~s2 & s3 & fen);
    assign tick_hit  = (pre == PRE_MAX);
    assign ms_wr     = we && (wadr == 3'd5);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            gpio_o  <= '0;
            gpio_oe <= '0;
            est     <= '0;
            ren     <= '0;
            fen     <= '0;
        end else begin
            s1 <= gpio_i;
            s2 <= s1;
            s3 <= s2;
            if (we && wadr == 3'd0) gpio_o  <= wd;
            if (we && wadr == 3'd1) gpio_oe <= wd;
            if (we && wadr == 3'd3) ren     <= wd;
            if (we && wadr == 3'd4) fen     <= wd;
            // new edges are OR-ed after the W1C mask so a coincident set survives
            if (we && wadr == 3'd2) est <= (est & ~wd) | edges;
            else                    est <= est | edges;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            tick <= 1'b0;
            ms   <= '0;
        end else begin
            pre  <= tick_hit ? '0 : pre + PW'(1);
            tick <= tick_hit;
            if (ms_wr)         ms <= wdata;
            else if (tick_hit) ms <= ms + 32'd1;
        end
    end

`ifdef GPIO_TMR_COMPARE_EN
    logic [31:0] cmp;
    logic        tflag, tie;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp   <= '1;
            tflag <= 1'b0;
            tie   <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (we && wadr == 3'd6) cmp <= wdata;
            if (we && wadr == 3'd7) tie <= wdata[1];
            if (tick_hit && !ms_wr && (ms + 32'd1) == cmp)
                tflag <= 1'b1;
            else if (we && wadr == 3'd7 && wdata[0])
                tflag <= 1'b0;
            irq <= (|est) | (tflag & tie);
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= |est;
    end
`endif

    always_comb begin
        rdata = '0;
        case (wadr)
            3'd0: rdata[GPIO_W-1:0] = s2;
            3'd1: rdata[GPIO_W-1:0] = gpio_oe;
            3'd2: rdata[GPIO_W-1:0] = est;
            3'd3: rdata[GPIO_W-1:0] = ren;
            3'd4: rdata[GPIO_W-1:0] = fen;
            3'd5: rdata = ms;
`ifdef GPIO_TMR_COMPARE_EN
            3'd6: rdata = cmp;
            3'd7: rdata[1:0] = {tie, tflag};
`endif
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_risc5_gpio_timer.sv
// Bench for risc5_gpio_timer: history-based reference model checked every cycle, plus directed literal checks.
module tb_risc5_gpio_timer;

    localparam int W  = 8;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [2:0]  wadr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [W-1:0] gpio_i = '0;
    logic [W-1:0] gpio_o, gpio_oe;
    logic        tick, irq;

    int n_chk  = 0;
    int n_fail = 0;
    bit armed  = 0;

    risc5_gpio_timer #(.GPIO_W(W), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .sel(sel), .rd(rd), .wr(wr), .wadr(wadr),
        .wdata(wdata), .rdata(rdata), .gpio_i(gpio_i), .gpio_o(gpio_o),
        .gpio_oe(gpio_oe), .tick(tick), .irq(irq)
    );

    always #5 clk = ~clk;

`ifdef GPIO_TMR_COMPARE_EN
    localparam bit CMP_ON = 1'b1;
`else
    localparam bit CMP_ON = 1'b0;
`endif

    // ---------------- reference model ----------------
    logic [W-1:0] samp[$];           // pin values sampled at each edge since reset
    logic [W-1:0] m_o, m_oe, m_est, m_ren, m_fen, m_edges, m_s2, m_s3, m_wd;
    logic [31:0]  m_ms, m_cmp;
    logic         m_tflag, m_tie, m_irq, m_tick, m_irq_next, m_tk, m_we;
    int unsigned  m_n;

    function automatic logic [W-1:0] past(int k);
        if (samp.size() >= k) return samp[samp.size() - k];
        return '0;
    endfunction

    function automatic logic [31:0] m_rd(logic [2:0] a);
        case (a)
            3'd0: return 32'(past(2));
            3'd1: return 32'(m_oe);
            3'd2: return 32'(m_est);
            3'd3: return 32'(m_ren);
            3'd4: return 32'(m_fen);
            3'd5: return m_ms;
            3'd6: return CMP_ON ? m_cmp : 32'd0;
            default: return CMP_ON ? {30'd0, m_tie, m_tflag} : 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            samp.delete();
            m_o = '0; m_oe = '0; m_est = '0; m_ren = '0; m_fen = '0;
            m_ms = '0; m_cmp = '1; m_tflag = 0; m_tie = 0; m_irq = 0; m_tick = 0; m_n = 0;
        end else begin
            m_s2 = past(2);
            m_s3 = past(3);
            m_edges = ((m_s2 & ~m_s3) & m_ren) | ((~m_s2 & m_s3) & m_fen);
            m_irq_next = (|m_est) | (CMP_ON && m_tflag && m_tie);
            m_we = sel && wr;
            m_wd = wdata[W-1:0];
            m_n++;
            m_tk = (m_n % TD) == 0;
            if (m_we && wadr == 3'd2) m_est = m_est & ~m_wd;
            m_est = m_est | m_edges;
            if (m_we && wadr == 3'd0) m_o = m_wd;
            if (m_we && wadr == 3'd1) m_oe = m_wd;
            if (m_we && wadr == 3'd3) m_ren = m_wd;
            if (m_we && wadr == 3'd4) m_fen = m_wd;
            if (m_we && wadr == 3'd7 && wdata[0]) m_tflag = 0;
            if (m_we && wadr == 3'd5) m_ms = wdata;
            else if (m_tk) begin
                m_ms = m_ms + 1;
                if (m_ms == m_cmp) m_tflag = 1;
            end
            if (m_we && wadr == 3'd6) m_cmp = wdata;
            if (m_we && wadr == 3'd7) m_tie = wdata[1];
            m_tick = m_tk;
            m_irq = m_irq_next;
            samp.push_back(gpio_i);
            if (samp.size() > 8) void'(samp.pop_front());
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        wait (armed);
        forever begin
            @(posedge clk);
            #1;
            chk("m_gpio_o", 32'(gpio_o), 32'(m_o));
            chk("m_gpio_oe", 32'(gpio_oe), 32'(m_oe));
            chk("m_tick", 32'(tick), 32'(m_tick));
            chk("m_irq", 32'(irq), 32'(m_irq));
            chk("m_rdata", rdata, m_rd(wadr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr_reg(logic [2:0] a, logic [31:0] d);
        sel = 1; wr = 1; wadr = a; wdata = d;
        @(posedge clk);
        #2;
        sel = 0; wr = 0;
    endtask

    task automatic rd_chk(string nm, logic [2:0] a, logic [31:0] exp);
        sel = 1; wadr = a;
        #1;
        chk(nm, rdata, exp);
    endtask

    task automatic wait_tick();
        int k = 0;
        while (tick !== 1'b1 && k < 3 * TD) begin
            cycles(1);
            k++;
        end
        chk("tick_sync", 32'(tick), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        cycles(2);
        armed = 1;
        rd_chk("rst_cmp", 3'd6, CMP_ON ? 32'hFFFF_FFFF : 32'd0);
        chk("rst_outs", {gpio_o, gpio_oe, 6'd0, tick, irq}, 32'd0);
        rst = 0;
        cycles(2);
        rst = 1;                          // reset mid-count
        cycles(1);
        chk("rst_mid", {gpio_o, gpio_oe, 6'd0, tick, irq}, 32'd0);
        rd_chk("rst_ms", 3'd5, 32'd0);
        rst = 0;
        cycles(TD - 1);
        chk("tick_early", 32'(tick), 32'd0);
        cycles(1);
        chk("tick_first", 32'(tick), 32'd1);
        cycles(1);
        chk("tick_pulse", 32'(tick), 32'd0);

        // GPIO outputs and input sync
        wr_reg(3'd1, 32'h0000_000F);
        chk("oe_0f", 32'(gpio_oe), 32'h0F);
        wr_reg(3'd0, 32'h0000_00A5);
        chk("o_a5", 32'(gpio_o), 32'hA5);
        wr_reg(3'd1, 32'hFFFF_FF0F);
        rd_chk("oe_mask", 3'd1, 32'h0000_000F);
        gpio_i = 8'h3C;
        wadr = 3'd0;
        cycles(1);
        rd_chk("pin_1edge", 3'd0, 32'h0);
        cycles(1);
        rd_chk("pin_2edge", 3'd0, 32'h3C);

        // Edge detection
        gpio_i = 8'hBC;
        cycles(4);
        wr_reg(3'd3, 32'h01);
        wr_reg(3'd4, 32'h80);
        cycles(3);
        rd_chk("no_retro", 3'd2, 32'h0);
        gpio_i = 8'h3D;
        cycles(2);
        rd_chk("est_e2", 3'd2, 32'h0);
        cycles(1);
        rd_chk("est_e3", 3'd2, 32'h81);
        chk("irq_e3", 32'(irq), 32'd0);
        cycles(1);
        chk("irq_e4", 32'(irq), 32'd1);
        wr_reg(3'd2, 32'hFF);
        rd_chk("est_clr", 3'd2, 32'h0);
        cycles(1);
        chk("irq_drop", 32'(irq), 32'd0);
        gpio_i = 8'h3F;
        cycles(4);
        gpio_i = 8'h3D;
        cycles(4);
        rd_chk("pin1_none", 3'd2, 32'h0);
        gpio_i = 8'h3C;
        cycles(4);
        gpio_i = 8'h3D;
        cycles(2);
        wr_reg(3'd2, 32'h01);             // W1C on the edge that sets bit0
        rd_chk("set_wins", 3'd2, 32'h01);
        wr_reg(3'd2, 32'hFF);
        cycles(2);
        chk("irq_idle", 32'(irq), 32'd0);

        // ms wrap and write-in-tick-cycle
        wait_tick();
        wr_reg(3'd5, 32'hFFFF_FFFE);
        cycles(TD - 1);
        rd_chk("ms_ff", 3'd5, 32'hFFFF_FFFF);
        cycles(TD);
        rd_chk("ms_wrap", 3'd5, 32'h0);
        wait_tick();
        cycles(TD - 1);
        wr_reg(3'd5, 32'h0000_0100);
        chk("wr_on_tick", {31'd0, tick}, 32'd1);
        rd_chk("ms_wr_wins", 3'd5, 32'h100);

        // compare
        wait_tick();
        wr_reg(3'd6, 32'd5);
        wr_reg(3'd7, 32'd2);
        wr_reg(3'd5, 32'd3);
        cycles(1);
        rd_chk("ms_4", 3'd5, 32'd4);
        rd_chk("r7_a", 3'd7, CMP_ON ? 32'd2 : 32'd0);
        cycles(TD);
        rd_chk("r7_b", 3'd7, CMP_ON ? 32'd3 : 32'd0);
        chk("irq_cmp0", 32'(irq), 32'd0);
        cycles(1);
        chk("irq_cmp1", 32'(irq), CMP_ON ? 32'd1 : 32'd0);
        wr_reg(3'd7, 32'd3);
        rd_chk("r7_clr", 3'd7, CMP_ON ? 32'd2 : 32'd0);
        cycles(1);
        chk("irq_cmp_clr", 32'(irq), 32'd0);
        cycles(2 * TD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
